issue_scoreboard: RTL and testbench

- Issue controller between the ID stage and EXE. It tracks in-flight register writes with per-register pending counters.
- It blocks issue when an instruction has a RAW hazard, and serialises the multi-cycle mul/div unit.
- It drains and clears itself on a pipeline flush.
- ID drives its right_ready from issue_ok; the scoreboard observes writeback to retire pending writes.

---
 rtl/issue_scoreboard_pkg.sv | 18 +
 rtl/issue_scoreboard_sb_counter.sv | 29 ++
 rtl/issue_scoreboard.sv | 126 ++++++++++++
 tb/tb_issue_scoreboard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared types and defaults for the issue scoreboard
package issue_scoreboard_pkg;

  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 2;
  localparam int IDX_W     = 5;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } run_state_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// rtl/issue_scoreboard_sb_counter.sv - per-register pending-write counter
// Saturates at both ends; err flags a retire against an empty counter.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign err = dec && !inc && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW/WAW/mul-div issue gating between ID and EXE
// Tracks in-flight register writes and drains itself after a pipeline flush.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MD_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             exe_ready,
  input  logic [IDX_W-1:0] id_src1_idx,
  input  logic             id_src1_use,
  input  logic [IDX_W-1:0] id_src2_idx,
  input  logic             id_src2_use,
  input  logic             id_wreg_en,
  input  logic [IDX_W-1:0] id_wreg_idx,
  input  logic             id_md_op,
  input  logic             wb_valid,
  input  logic             wb_wreg_en,
  input  logic [IDX_W-1:0] wb_wreg_idx,
  input  logic             flush,
  input  logic             pipe_empty,
  output logic             issue_ok,
  output logic             issue_fire,
  output logic [NREG-1:0]  pend_mask,
  output logic             md_busy,
  output logic             draining,
  output logic             sb_err
);

  localparam int               MD_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            underflow;
  run_state_e                 state;
  md_state_e                  md_state;
  logic [MD_W-1:0]            md_cnt;
  logic                       raw1;
  logic                       raw2;
  logic                       waw_full;
  logic                       md_hz;
  logic                       drain_done;

  assign raw1     = id_src1_use && (id_src1_idx != '0) && (cnt[id_src1_idx] != '0);
  assign raw2     = id_src2_use && (id_src2_idx != '0) && (cnt[id_src2_idx] != '0);
  assign waw_full = id_wreg_en && (id_wreg_idx != '0) && (cnt[id_wreg_idx] == CNT_MAX);
  assign md_hz    = id_md_op && md_busy;

  assign issue_ok   = (state == RUN) && !raw1 && !raw2 && !waw_full && !md_hz && !flush;
  assign issue_fire = id_valid && exe_ready && issue_ok;
  assign drain_done = (state == DRAIN) && pipe_empty;
  assign md_busy    = (md_state == MD_BUSY);
  assign draining   = (state == DRAIN);

  // r0 is hardwired zero, so it never gets a counter.
  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;
  assign pend_mask[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic inc;
    logic dec;

    assign inc = issue_fire && id_wreg_en && (id_wreg_idx == IDX_W'(i));
    assign dec = wb_valid && wb_wreg_en && (wb_wreg_idx == IDX_W'(i));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .dec   (dec),
      .clear (drain_done),
      .cnt   (cnt[i]),
      .err   (underflow[i])
    );

    assign pend_mask[i] = (cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      sb_err   <= 1'b0;
    end else begin
      sb_err <= sb_err || (|underflow);

      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (pipe_empty) state <= RUN;
        default: state <= RUN;
      endcase

      // A completed drain abandons any mul/div still counting down.
      if (drain_done) begin
        md_state <= MD_IDLE;
        md_cnt   <= '0;
      end else begin
        case (md_state)
          MD_IDLE: begin
            if (issue_fire && id_md_op) begin
              md_cnt   <= MD_W'(MD_LAT - 1);
              md_state <= MD_BUSY;
            end
          end
          MD_BUSY: begin
            if (md_cnt == '0) begin
              md_state <= MD_IDLE;
            end else begin
              md_cnt <= md_cnt - 1'b1;
            end
          end
          default: md_state <= MD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed and randomized checks against a behavioural model
module tb_issue_scoreboard;

  localparam int MD_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        exe_ready;
  logic [4:0]  id_src1_idx;
  logic        id_src1_use;
  logic [4:0]  id_src2_idx;
  logic        id_src2_use;
  logic        id_wreg_en;
  logic [4:0]  id_wreg_idx;
  logic        id_md_op;
  logic        wb_valid;
  logic        wb_wreg_en;
  logic [4:0]  wb_wreg_idx;
  logic        flush;
  logic        pipe_empty;
  logic        issue_ok;
  logic        issue_fire;
  logic [31:0] pend_mask;
  logic        md_busy;
  logic        draining;
  logic        sb_err;

  int mcnt[32];
  int md_rem;
  bit m_drain;
  bit m_err;
  bit m_ok;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.NREG(32), .CNT_W(2), .MD_LAT(MD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .exe_ready   (exe_ready),
    .id_src1_idx (id_src1_idx),
    .id_src1_use (id_src1_use),
    .id_src2_idx (id_src2_idx),
    .id_src2_use (id_src2_use),
    .id_wreg_en  (id_wreg_en),
    .id_wreg_idx (id_wreg_idx),
    .id_md_op    (id_md_op),
    .wb_valid    (wb_valid),
    .wb_wreg_en  (wb_wreg_en),
    .wb_wreg_idx (wb_wreg_idx),
    .flush       (flush),
    .pipe_empty  (pipe_empty),
    .issue_ok    (issue_ok),
    .issue_fire  (issue_fire),
    .pend_mask   (pend_mask),
    .md_busy     (md_busy),
    .draining    (draining),
    .sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit model_ok();
    bit ok;
    ok = !m_drain && !flush;
    if (id_src1_use && id_src1_idx != 0 && mcnt[id_src1_idx] > 0) ok = 0;
    if (id_src2_use && id_src2_idx != 0 && mcnt[id_src2_idx] > 0) ok = 0;
    if (id_wreg_en && id_wreg_idx != 0 && mcnt[id_wreg_idx] == 3) ok = 0;
    if (id_md_op && md_rem > 0) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (mcnt[i] > 0);
    return m;
  endfunction

  task automatic idle();
    reset = 0; id_valid = 0; exe_ready = 0;
    id_src1_idx = 0; id_src1_use = 0; id_src2_idx = 0; id_src2_use = 0;
    id_wreg_en = 0; id_wreg_idx = 0; id_md_op = 0;
    wb_valid = 0; wb_wreg_en = 0; wb_wreg_idx = 0;
    flush = 0; pipe_empty = 0;
  endtask

  task automatic eval();
    #1;
    m_ok = model_ok();
    check("issue_ok", issue_ok, m_ok);
    check("issue_fire", issue_fire, id_valid && exe_ready && m_ok);
    check("pend_mask", pend_mask, model_mask());
    check("md_busy", md_busy, md_rem > 0);
    check("draining", draining, m_drain);
    check("sb_err", sb_err, m_err);
  endtask

  task automatic tick();
    bit fire;
    bit done;
    bit inc;
    bit dec;
    fire = id_valid && exe_ready && m_ok;
    done = m_drain && pipe_empty;
    if (reset) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      md_rem = 0; m_drain = 0; m_err = 0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        inc = fire && id_wreg_en && id_wreg_idx == i;
        dec = wb_valid && wb_wreg_en && wb_wreg_idx == i;
        if (dec && !inc) begin
          if (mcnt[i] == 0) m_err = 1;
          else mcnt[i]--;
        end else if (inc && !dec && mcnt[i] < 3) begin
          mcnt[i]++;
        end
      end
      if (done) for (int i = 0; i < 32; i++) mcnt[i] = 0;
      if (done) md_rem = 0;
      else if (fire && id_md_op) md_rem = MD_LAT;
      else if (md_rem > 0) md_rem--;
      if (!m_drain && flush) m_drain = 1;
      else if (done) m_drain = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    @(negedge clk);
    reset = 1; eval(); tick();
    idle(); eval();
    check("reset_ok", issue_ok, 1); check("reset_mask", pend_mask, 0); tick();

    // RAW stall on r4 until its writeback has retired
    id_valid = 1; exe_ready = 1; id_wreg_en = 1; id_wreg_idx = 4; eval(); tick();
    id_wreg_en = 0; id_src1_use = 1; id_src1_idx = 4;
    for (int k = 0; k < 2; k++) begin
      eval(); check("raw_stall", issue_ok, 0); check("raw_pend", pend_mask[4], 1); tick();
    end
    wb_valid = 1; wb_wreg_en = 1; wb_wreg_idx = 4; eval(); check("raw_wb_same", issue_ok, 0); tick();
    wb_valid = 0; eval(); check("raw_release", issue_ok, 1); tick();

    // r0 reads and writes never create hazards
    idle(); id_valid = 1; exe_ready = 1; id_wreg_en = 1; id_src1_use = 1; id_src2_use = 1;
    for (int k = 0; k < 3; k++) begin
      eval(); check("r0_ok", issue_ok, 1); check("r0_mask", pend_mask, 0); tick();
    end

    // saturation of r5 and simultaneous issue/retire
    idle(); id_valid = 1; exe_ready = 1; id_wreg_en = 1; id_wreg_idx = 5;
    for (int k = 0; k < 3; k++) begin
      eval(); check("sat_fill", issue_ok, 1); tick();
    end
    eval(); check("sat_full", issue_ok, 0); tick();
    id_valid = 0; wb_valid = 1; wb_wreg_en = 1; wb_wreg_idx = 5; eval(); tick();
    id_valid = 1; eval(); check("sat_wb_issue", issue_fire, 1); tick();
    wb_valid = 0; eval(); check("sat_refill", issue_ok, 1); tick();
    eval(); check("sat_full2", issue_ok, 0); tick();
    id_valid = 0; wb_valid = 1;
    for (int k = 0; k < 3; k++) begin eval(); tick(); end
    wb_valid = 0; eval(); check("sat_empty", pend_mask[5], 0); tick();

    // mul/div occupancy
    idle(); id_valid = 1; exe_ready = 1; id_md_op = 1; id_wreg_en = 1; id_wreg_idx = 8;
    eval(); check("md_first", issue_fire, 1); tick();
    id_wreg_en = 0;
    for (int k = 0; k < MD_LAT; k++) begin
      eval(); check("md_busy_on", md_busy, 1); check("md_block", issue_ok, 0); tick();
    end
    eval(); check("md_free", issue_ok, 1); check("md_busy_off", md_busy, 0); tick();
    id_valid = 0;
    for (int k = 0; k < MD_LAT + 1; k++) begin eval(); tick(); end

    // flush and drain
    idle(); id_valid = 1; exe_ready = 1; id_wreg_en = 1; id_wreg_idx = 6; eval(); tick();
    id_wreg_en = 0; flush = 1; eval(); check("flush_same", issue_ok, 0); tick();
    flush = 0;
    for (int k = 0; k < 3; k++) begin
      eval(); check("drain_flag", draining, 1); check("drain_block", issue_ok, 0); tick();
    end
    pipe_empty = 1; eval(); tick();
    pipe_empty = 0; eval(); check("drain_done", draining, 0); check("drain_clear", pend_mask, 0); tick();

    // underflow error, then reset during mul/div
    idle(); wb_valid = 1; wb_wreg_en = 1; wb_wreg_idx = 7; eval(); tick();
    wb_valid = 0; eval(); check("err_set", sb_err, 1); tick();
    id_valid = 1; exe_ready = 1; id_md_op = 1; id_wreg_en = 1; id_wreg_idx = 9; eval(); tick();
    idle(); eval(); check("md_before_rst", md_busy, 1);
    reset = 1; tick();
    reset = 0; eval();
    check("rst_md", md_busy, 0); check("rst_err", sb_err, 0); check("rst_mask", pend_mask, 0); tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      exe_ready   = ($urandom_range(0, 4) != 0);
      id_src1_use = ($urandom_range(0, 1) == 1);
      id_src2_use = ($urandom_range(0, 2) == 0);
      id_src1_idx = 5'($urandom_range(0, 7));
      id_src2_idx = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      id_wreg_en  = ($urandom_range(0, 3) != 0);
      id_wreg_idx = 5'($urandom_range(0, 7));
      id_md_op    = ($urandom_range(0, 5) == 0);
      wb_valid    = ($urandom_range(0, 1) == 1);
      wb_wreg_en  = ($urandom_range(0, 4) != 0);
      wb_wreg_idx = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 19) != 0) begin
        for (int t = 0; t < 8 && mcnt[wb_wreg_idx] == 0; t++) wb_wreg_idx = 5'($urandom_range(0, 7));
      end
      flush      = ($urandom_range(0, 39) == 0);
      pipe_empty = ($urandom_range(0, 2) == 0);
      eval();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
